// File: rtl/ps2_kbd_rx_pkg.sv
// ps2_kbd_rx_pkg: shared constants for the PS/2 keyboard receiver.
// The frame length, the FSM state encodings and the odd-parity check are defined here.
`timescale 1ns/1ps
package ps2_kbd_rx_pkg;

  // One PS/2 frame: start, 8 data bits LSB-first, odd parity, stop
  localparam int PS2_FRAME_BITS = 11;

  // FSM state encodings
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  // Odd parity holds when the 8 data bits plus the parity bit contain an odd number of ones
  function automatic logic parity_ok(input logic [8:0] data_par);
    return ^data_par;
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: synchronous scan-code FIFO with valid/ready read side.
// The pointers carry one extra wrap bit, so full and empty can be told apart.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
`timescale 1ns/1ps
module ps2_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       full,
  output logic       pop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [7:0]  mem_r [DEPTH];
  logic        empty_s;
  logic        full_s;
  logic        pop_s;
  logic        wr_en_s;

  assign empty_s  = (wr_ptr_r == rd_ptr_r);
  assign full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s    = rd_ready & ~empty_s;
  assign wr_en_s  = push & (~full_s | pop_s);

  assign rd_data  = mem_r[rd_ptr_r[AW-1:0]];
  assign rd_valid = ~empty_s;
  assign full     = full_s;
  assign pop      = pop_s;

  // Storage array: cleared on reset so the head reads zero, written on an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end
  end

  // Read and write pointers, wrapping naturally through the extra MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver.
// It synchronises ps2_clk/ps2_data and deframes 11-bit frames on ps2_clk falling edges.
// It checks the start, stop and odd-parity bits and queues good scan codes in ps2_rx_fifo.
// Optional macro PS2_RX_TIMEOUT_EN abandons a partial frame after TIMEOUT_CYCLES
// clk cycles with no falling edge.
`timescale 1ns/1ps
module ps2_kbd_rx
  import ps2_kbd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overflow,
  input  logic       overflow_clr,
  output logic       timeout
);

  localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

  logic [2:0] sync_clk_r;
  logic [2:0] sync_data_r;
  logic       fall_s;
  logic       bit_s;

  logic [0:0] state_r;
  logic [3:0] cnt_r;
  logic [9:0] buf_r;

  logic       stop_fall_s;
  logic       frame_good_s;
  logic       tmo_hit_s;

  logic       push_r;
  logic [7:0] push_data_r;
  logic       frame_err_r;
  logic       overflow_r;
  logic       timeout_r;

  logic       fifo_full_s;
  logic       fifo_pop_s;

  // Three-flop synchronisers, preset high to match an idle PS/2 bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_clk_r  <= 3'b111;
      sync_data_r <= 3'b111;
    end else begin
      sync_clk_r  <= {sync_clk_r[1:0], ps2_clk};
      sync_data_r <= {sync_data_r[1:0], ps2_data};
    end
  end

  // Data is taken at the same pipeline depth as the clock edge detect
  assign fall_s       = sync_clk_r[2] & ~sync_clk_r[1];
  assign bit_s        = sync_data_r[1];
  assign stop_fall_s  = fall_s & (state_r == ST_RECV) & (cnt_r == STOP_IDX);
  // Stop bit is the bit arriving now; it is never stored in buf_r
  assign frame_good_s = ~buf_r[0] & bit_s & parity_ok(buf_r[9:1]);

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_r;

  assign tmo_hit_s = (state_r == ST_RECV) & ~fall_s &
                     (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Cycles since the last falling edge while a frame is in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_r <= '0;
    end else if ((state_r != ST_RECV) || fall_s || tmo_hit_s) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end
`else
  logic unused_tmo_cfg_s;
  assign unused_tmo_cfg_s = ^32'(TIMEOUT_CYCLES);
  assign tmo_hit_s        = 1'b0;
`endif

  // Frame FSM: collect bits on each falling edge, return to IDLE after the stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      buf_r   <= 10'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (fall_s) begin
            buf_r[0] <= bit_s;
            cnt_r    <= 4'd1;
            state_r  <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (fall_s) begin
            if (cnt_r == STOP_IDX) begin
              cnt_r   <= 4'd0;
              state_r <= ST_IDLE;
            end else begin
              buf_r[cnt_r] <= bit_s;
              cnt_r        <= cnt_r + 4'd1;
            end
          end else if (tmo_hit_s) begin
            cnt_r   <= 4'd0;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          cnt_r   <= 4'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Frame verdict, registered: the push request or the error pulse follows the stop bit by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_r      <= 1'b0;
      push_data_r <= 8'h00;
      frame_err_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      push_r      <= stop_fall_s & frame_good_s;
      frame_err_r <= stop_fall_s & ~frame_good_s;
      timeout_r   <= tmo_hit_s;
      if (stop_fall_s) begin
        push_data_r <= buf_r[8:1];
      end
    end
  end

  // Sticky overflow: a clear wins over a same-cycle drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (overflow_clr) begin
      overflow_r <= 1'b0;
    end else if (push_r & fifo_full_s & ~fifo_pop_s) begin
      overflow_r <= 1'b1;
    end
  end

  ps2_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push_r),
    .push_data(push_data_r),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (fifo_full_s),
    .pop      (fifo_pop_s)
  );

  assign frame_err = frame_err_r;
  assign overflow  = overflow_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed plus randomised frames against a queue-based model of the receiver.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_ready = 1'b0;
  logic       overflow_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overflow;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // monitor counters
  int   err_pulses = 0;
  int   err_long = 0;
  int   tmo_pulses = 0;
  logic fe_q = 1'b0;
  logic to_q = 1'b0;

  // reference model
  logic [7:0] exp_q[$];
  logic       exp_ovf = 1'b0;
  int         exp_err = 0;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .frame_err(frame_err), .overflow(overflow), .overflow_clr(overflow_clr),
    .timeout(timeout)
  );

  // pulse monitor: counts rising edges and any cycle where a pulse stays high
  always @(posedge clk) begin
    fe_q <= frame_err;
    to_q <= timeout;
    if (frame_err && !fe_q) err_pulses <= err_pulses + 1;
    if (frame_err && fe_q)  err_long   <= err_long + 1;
    if (timeout && !to_q)   tmo_pulses <= tmo_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
  task automatic send_bits(input logic [7:0] b, input int kind, input int nbits);
    logic [10:0] fr;
    fr[0]   = (kind == 3);
    fr[8:1] = b;
    fr[9]   = ~(^b) ^ (kind == 1);
    fr[10]  = (kind != 2);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      #30 ps2_clk = 1'b0;
      #30 ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    #300;
  endtask

  task automatic send(input logic [7:0] b, input int kind);
    send_bits(b, kind, 11);
    if (kind == 0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(b);
      else exp_ovf = 1'b1;
    end else begin
      exp_err++;
    end
  endtask

  task automatic pop_expect(input string tag);
    logic [7:0] e;
    int n;
    n = 0;
    @(negedge clk);
    while (!rd_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_data"}, {24'd0, rd_data}, {24'd0, e});
    rd_ready = 1'b1;
    @(negedge clk);
    rd_ready = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop_expect(tag);
    @(negedge clk);
    check({tag, "_empty"}, {31'd0, rd_valid}, 32'd0);
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 1: single good frame, held with rd_ready low
    send(8'h1C, 0);
    @(negedge clk);
    check("t1_valid", {31'd0, rd_valid}, 32'd1);
    check("t1_data", {24'd0, rd_data}, {24'd0, exp_q[0]});
    check("t1_no_err", err_pulses, exp_err);
    drain("t1");

    // 2: two frames popped in order
    send(8'hF0, 0);
    send(8'h1C, 0);
    drain("t2");

    // 3: parity error
    send(8'h1C, 1);
    check("t3_err_cnt", err_pulses, exp_err);
    check("t3_err_width", err_long, 0);
    check("t3_no_valid", {31'd0, rd_valid}, 32'd0);

    // 4: overflow with nine frames
    for (int i = 1; i <= 9; i++) send(8'(i), 0);
    check("t4_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    check("t4_head", {24'd0, rd_data}, 32'h01);
    drain("t4");
    check("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
    clear_ovf();
    check("t4_ovf_clr", {31'd0, overflow}, {31'd0, exp_ovf});

    // 5: reset mid-frame
    send(8'h11, 0);
    send_bits(8'h77, 0, 5);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    check("t5_rst_empty", {31'd0, rd_valid}, 32'd0);
    send(8'h5A, 0);
    check("t5_count", {31'd0, rd_valid}, 32'd1);
    drain("t5");
    check("t5_no_err", err_pulses, exp_err);

`ifdef PS2_RX_TIMEOUT_EN
    // 6: partial frame abandoned by timeout
    send_bits(8'h33, 0, 4);
    repeat (4200) @(negedge clk);
    check("t6_timeout", tmo_pulses, 1);
    send(8'h29, 0);
    drain("t6");
    check("t6_no_err", err_pulses, exp_err);
`else
    check("t6_no_timeout", tmo_pulses, 0);
`endif

    // randomised frames, some corrupted
    for (int r = 0; r < 16; r++) begin
      logic [7:0] b;
      int kind;
      b = 8'($urandom_range(0, 255));
      kind = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      send(b, kind);
    end
    check("rnd_overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    check("rnd_err_cnt", err_pulses, exp_err);
    check("rnd_err_width", err_long, 0);
    drain("rnd");
    clear_ovf();
    check("rnd_ovf_clr", {31'd0, overflow}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
